// File: rtl/mem_stage_pkg.sv
// Shared processor package: SRAM access FSM encoding, default data-memory base
// and the byte-address to SRAM word-index mapping.
package mem_stage_pkg;

  localparam logic [31:0] MEM_BASE_DEFAULT = 32'd1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } mem_state_e;

  // Word index keeps 17 bits; anything above wraps silently.
  function automatic logic [16:0] word_index(input logic [31:0] addr,
                                             input logic [31:0] base);
    logic [31:0] off;
    off = addr - base;
    return off[18:2];
  endfunction

endpackage

// File: rtl/sram_controller.sv
// Sequences one 32-bit access as two 16-bit SRAM halves (low then high), each
// held WAIT_CYCLES cycles, and assembles read data.
module sram_controller
  import mem_stage_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        wr_i,
  input  logic [16:0] index_i,
  input  logic [31:0] wdata_i,
  input  logic [15:0] sram_dq_i,
  output logic [17:0] sram_addr_o,
  output logic [15:0] sram_dq_o,
  output logic        sram_dq_oe_o,
  output logic        sram_we_n_o,
  output logic        freeze_o,
  output logic        fin_o,
  output logic [31:0] rd_word_o
);

  localparam logic [2:0] LAST = 3'(WAIT_CYCLES - 1);

  mem_state_e  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] lo_q, lo_d;
  logic        last, busy, half;

  assign last = (cnt_q == LAST);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 3'd1;
    lo_d     = lo_q;
    freeze_o = 1'b0;
    fin_o    = 1'b0;
    busy     = 1'b0;
    half     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req_i) begin
          state_d  = LOW;
          freeze_o = 1'b1;
        end
      end
      LOW: begin
        busy     = 1'b1;
        freeze_o = 1'b1;
        if (last) begin
          state_d = HIGH;
          cnt_d   = '0;
          lo_d    = sram_dq_i;
        end
      end
      HIGH: begin
        busy     = 1'b1;
        half     = 1'b1;
        freeze_o = 1'b1;
        if (last) begin
          state_d = DONE;
          cnt_d   = '0;
          fin_o   = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outside LOW/HIGH the bus is parked: no strobe, no drive, address 0.
  assign sram_addr_o  = busy ? {index_i, half} : 18'd0;
  assign sram_dq_oe_o = busy & wr_i;
  assign sram_we_n_o  = ~(busy & wr_i);
  assign sram_dq_o    = (busy & wr_i) ? (half ? wdata_i[31:16] : wdata_i[15:0]) : 16'd0;
  assign rd_word_o    = {sram_dq_i, lo_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: control passthroughs, load result register and the SRAM
// controller. Define MEM_STAGE_LAST_WORD_CACHE_EN for a one-entry last-word cache.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] MEM_BASE    = MEM_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN_in,
  input  logic        MEM_W_EN_in,
  input  logic        WB_EN_in,
  input  logic [3:0]  Dest_in,
  input  logic [31:0] ALU_Res_in,
  input  logic [31:0] Val_Rm_in,
  output logic        WB_EN_out,
  output logic        MEM_R_EN_out,
  output logic [3:0]  Dest_out,
  output logic [31:0] ALU_Res_out,
  output logic [31:0] MEM_Result,
  output logic        freeze,
  output logic [17:0] SRAM_ADDR,
  output logic [15:0] SRAM_DQ_out,
  input  logic [15:0] SRAM_DQ_in,
  output logic        SRAM_DQ_oe,
  output logic        SRAM_WE_N
);

  logic [16:0] index;
  logic        wr, rd, req, fin;
  logic [31:0] rd_word, result_q, result_d;

  assign WB_EN_out    = WB_EN_in;
  assign MEM_R_EN_out = MEM_R_EN_in;
  assign Dest_out     = Dest_in;
  assign ALU_Res_out  = ALU_Res_in;

  assign index = word_index(ALU_Res_in, MEM_BASE);
  // Both enables set is a store.
  assign wr    = MEM_W_EN_in;
  assign rd    = MEM_R_EN_in & ~MEM_W_EN_in;

`ifdef MEM_STAGE_LAST_WORD_CACHE_EN
  logic        valid_q, valid_d, hit;
  logic [16:0] tag_q, tag_d;
  logic [31:0] data_q, data_d;

  // Upstream is frozen while the FSM is busy, so a matching read can only be
  // presented here while the controller is idle.
  assign hit        = rd & valid_q & (tag_q == index);
  assign req        = (rd | wr) & ~hit;
  assign MEM_Result = hit ? data_q : result_q;

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    data_d   = data_q;
    result_d = result_q;
    if (fin) begin
      valid_d = 1'b1;
      tag_d   = index;
      data_d  = wr ? Val_Rm_in : rd_word;
      if (!wr) result_d = rd_word;
    end else if (hit) begin
      result_d = data_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end
`else
  assign req        = rd | wr;
  assign MEM_Result = result_q;

  always_comb begin
    result_d = result_q;
    if (fin && !wr) result_d = rd_word;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) result_q <= '0;
    else      result_q <= result_d;
  end

  sram_controller #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .wr_i        (wr),
    .index_i     (index),
    .wdata_i     (Val_Rm_in),
    .sram_dq_i   (SRAM_DQ_in),
    .sram_addr_o (SRAM_ADDR),
    .sram_dq_o   (SRAM_DQ_out),
    .sram_dq_oe_o(SRAM_DQ_oe),
    .sram_we_n_o (SRAM_WE_N),
    .freeze_o    (freeze),
    .fin_o       (fin),
    .rd_word_o   (rd_word)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected SRAM write beats and load results are
// queued when an access is driven and compared as the DUT produces them.
module tb_mem_stage;

  localparam int W   = 2;
  localparam int FRZ = 1 + 2 * W;
`ifdef MEM_STAGE_LAST_WORD_CACHE_EN
  localparam int HIT_FRZ = 0;
`else
  localparam int HIT_FRZ = FRZ;
`endif

  logic        clk = 1'b0, rst = 1'b0;
  logic        MEM_R_EN_in = 1'b0, MEM_W_EN_in = 1'b0, WB_EN_in = 1'b0;
  logic [3:0]  Dest_in = '0;
  logic [31:0] ALU_Res_in = '0, Val_Rm_in = '0;
  logic        WB_EN_out, MEM_R_EN_out, freeze, SRAM_DQ_oe, SRAM_WE_N;
  logic [3:0]  Dest_out;
  logic [31:0] ALU_Res_out, MEM_Result;
  logic [17:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_out, SRAM_DQ_in;

  mem_stage #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in), .WB_EN_in(WB_EN_in),
    .Dest_in(Dest_in), .ALU_Res_in(ALU_Res_in), .Val_Rm_in(Val_Rm_in),
    .WB_EN_out(WB_EN_out), .MEM_R_EN_out(MEM_R_EN_out), .Dest_out(Dest_out),
    .ALU_Res_out(ALU_Res_out), .MEM_Result(MEM_Result), .freeze(freeze),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_out(SRAM_DQ_out), .SRAM_DQ_in(SRAM_DQ_in),
    .SRAM_DQ_oe(SRAM_DQ_oe), .SRAM_WE_N(SRAM_WE_N)
  );

  always #5 clk = ~clk;

  // SRAM model, 256 words visible through the low address bits.
  logic [15:0] sram [0:255];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_a = '0;
  logic [15:0] pre_d = '0;
  assign SRAM_DQ_in = sram[SRAM_ADDR[7:0]];
  always @(posedge clk) begin
    if (pre_we) sram[pre_a] <= pre_d;
    else if (!SRAM_WE_N && SRAM_DQ_oe) sram[SRAM_ADDR[7:0]] <= SRAM_DQ_out;
  end

  typedef struct packed {
    logic [17:0] a;
    logic [15:0] d;
  } beat_t;

  beat_t       wq[$];
  logic [31:0] rq[$];
  logic [31:0] ref_mem [logic [16:0]];
  logic [31:0] last_res = '0;
  int          n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [16:0] idx_of(input logic [31:0] a);
    logic [31:0] o;
    o = a - 32'd1024;
    return o[18:2];
  endfunction

  // Every write strobe must match the next queued beat.
  always @(negedge clk) begin
    if (rst && !SRAM_WE_N) begin
      if (wq.size() == 0) chk("wr_unexpected", 32'(SRAM_ADDR), 32'hFFFF_FFFF);
      else begin
        beat_t b;
        b = wq.pop_front();
        chk("wr_addr", 32'(SRAM_ADDR), 32'(b.a));
        chk("wr_data", 32'(SRAM_DQ_out), 32'(b.d));
        chk("wr_oe", 32'(SRAM_DQ_oe), 32'd1);
      end
    end
  end

  task automatic push_wr(input logic [16:0] ix, input logic [31:0] d, input int nhi);
    for (int i = 0; i < W; i++) wq.push_back('{a: {ix, 1'b0}, d: d[15:0]});
    for (int i = 0; i < nhi; i++) wq.push_back('{a: {ix, 1'b1}, d: d[31:16]});
  endtask

  task automatic mem_op(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input int exp_frz);
    logic [16:0] ix;
    int          n;
    ix = idx_of(addr);
    @(posedge clk); #1;
    MEM_R_EN_in = rd; MEM_W_EN_in = wr; ALU_Res_in = addr; Val_Rm_in = data;
    if (wr) begin
      push_wr(ix, data, W);
      ref_mem[ix] = data;
    end else if (rd) begin
      rq.push_back(ref_mem.exists(ix) ? ref_mem[ix] : 32'h0);
    end
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!freeze) break;
      n++;
      chk("beat_addr", 32'(SRAM_ADDR), (n == 1) ? 32'd0 : 32'({ix, 1'(n > W + 1)}));
    end
    chk("freeze_cycles", n, exp_frz);
    chk("idle_addr", 32'(SRAM_ADDR), 32'd0);
    chk("idle_we_n", 32'(SRAM_WE_N), 32'd1);
    if (rd && !wr) begin
      last_res = rq.pop_front();
      chk("mem_result", MEM_Result, last_res);
    end else begin
      chk("result_hold", MEM_Result, last_res);
    end
    @(posedge clk); #1;
    MEM_R_EN_in = 1'b0; MEM_W_EN_in = 1'b0;
    chk("wq_drained", wq.size(), 0);
  endtask

  initial begin
    // Preload words for byte address 1028 while reset is held.
    ref_mem[17'd1] = 32'h1234_5678;
    @(negedge clk); pre_we = 1'b1; pre_a = 8'd2; pre_d = 16'h5678;
    @(negedge clk); pre_a = 8'd3; pre_d = 16'h1234;
    @(negedge clk); pre_we = 1'b0;
    chk("rst_freeze", 32'(freeze), 32'd0);
    chk("rst_we_n", 32'(SRAM_WE_N), 32'd1);
    chk("rst_oe", 32'(SRAM_DQ_oe), 32'd0);
    chk("rst_result", MEM_Result, 32'd0);
    chk("rst_addr", 32'(SRAM_ADDR), 32'd0);
    #2 rst = 1'b1;

    // Non-memory op: combinational passthrough, no stall.
    @(posedge clk); #1;
    ALU_Res_in = 32'd7; Dest_in = 4'hA; WB_EN_in = 1'b1;
    #1;
    chk("nm_freeze", 32'(freeze), 32'd0);
    chk("nm_we_n", 32'(SRAM_WE_N), 32'd1);
    chk("nm_alu_out", ALU_Res_out, 32'd7);
    chk("nm_dest_out", 32'(Dest_out), 32'hA);
    chk("nm_wb_out", 32'(WB_EN_out), 32'd1);
    MEM_R_EN_in = 1'b1; #1;
    chk("nm_mem_r_out", 32'(MEM_R_EN_out), 32'd1);
    MEM_R_EN_in = 1'b0;

    mem_op(1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF, FRZ);
    mem_op(1'b1, 1'b0, 32'd1028, 32'h0, FRZ);
    mem_op(1'b1, 1'b0, 32'd1028, 32'h0, HIT_FRZ);
    mem_op(1'b0, 1'b1, 32'd1028, 32'h0, FRZ);
    mem_op(1'b1, 1'b0, 32'd1028, 32'h0, HIT_FRZ);
    mem_op(1'b1, 1'b1, 32'd1032, 32'hCAFE_F00D, FRZ);
    mem_op(1'b1, 1'b0, 32'd1032, 32'h0, HIT_FRZ);
    mem_op(1'b0, 1'b1, 32'd1036, 32'h0BAD_F00D, FRZ);
    mem_op(1'b1, 1'b0, 32'd1036 + (32'd1 << 19), 32'h0, HIT_FRZ);
    mem_op(1'b1, 1'b0, 32'd1024, 32'h0, FRZ);

    // Reset during the first HIGH cycle of a write abandons the access.
    @(posedge clk); #1;
    MEM_W_EN_in = 1'b1; ALU_Res_in = 32'd1040; Val_Rm_in = 32'h1111_2222;
    push_wr(idx_of(32'd1040), 32'h1111_2222, 1);
    for (int k = 0; k < W + 2; k++) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    last_res = 32'h0;
    chk("mr_we_n", 32'(SRAM_WE_N), 32'd1);
    chk("mr_oe", 32'(SRAM_DQ_oe), 32'd0);
    chk("mr_addr", 32'(SRAM_ADDR), 32'd0);
    chk("mr_result", MEM_Result, 32'd0);
    chk("mr_freeze_req", 32'(freeze), 32'd1);
    MEM_W_EN_in = 1'b0; #1;
    chk("mr_freeze_noreq", 32'(freeze), 32'd0);
    chk("mr_wq_drained", wq.size(), 0);
    @(negedge clk); #2 rst = 1'b1;

    // After reset nothing is cached: a read pays full latency.
    mem_op(1'b1, 1'b0, 32'd1028, 32'h0, FRZ);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, cycles each 16-bit SRAM half-access is held (legal 1..7).
REQ-002 SHALL have parameter MEM_BASE, default 32'd1024, byte address mapped to SRAM word 0.
REQ-003 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports MEM_R_EN_in, MEM_W_EN_in, WB_EN_in  in  1 each  control bits from the EXE/MEM register.
REQ-006 SHALL have ports Dest_in  in  4  destination register; ALU_Res_in  in  32  byte address or ALU result; Val_Rm_in  in  32  store data.
REQ-007 SHALL have ports WB_EN_out, MEM_R_EN_out  out  1; Dest_out  out  4; ALU_Res_out  out  32  passthroughs to the MEM/WB register.
REQ-008 SHALL have port MEM_Result  out  32  load data.
REQ-009 SHALL have port freeze  out  1  stall request to all upstream pipeline registers.
REQ-010 SHALL have ports SRAM_ADDR  out  18; SRAM_DQ_out  out  16; SRAM_DQ_in  in  16; SRAM_DQ_oe  out  1; SRAM_WE_N  out  1 (active-low write strobe).

Function
REQ-011 Passthrough outputs SHALL equal their inputs combinationally.
REQ-012 Word index SHALL be (ALU_Res_in - MEM_BASE) >> 2; SRAM_ADDR SHALL be {index[16:0], half}, half 0 = bits 15:0, half 1 = bits 31:16; higher index bits dropped (wrap-around, no error).
REQ-013 FSM states SHALL be IDLE, LOW, HIGH, DONE.
REQ-014 IDLE -> LOW when MEM_R_EN_in or MEM_W_EN_in; else stay IDLE.
REQ-015 LOW -> HIGH and HIGH -> DONE after WAIT_CYCLES cycles each, counted by a 3-bit counter cleared on every state entry.
REQ-016 DONE -> IDLE unconditionally after one cycle.
REQ-017 freeze SHALL be 1 in IDLE with a request, in LOW and in HIGH; 0 in DONE and in IDLE without a request; total stall = 1 + 2*WAIT_CYCLES cycles (5 at default).
REQ-018 Write: SRAM_DQ_oe = 1 and SRAM_WE_N = 0 throughout LOW/HIGH, SRAM_DQ_out = Val_Rm_in[15:0] in LOW, [31:16] in HIGH.
REQ-019 Read: SRAM_WE_N = 1, SRAM_DQ_oe = 0; SRAM_DQ_in captured on last cycle of LOW (low half) and of HIGH (high half).
REQ-020 MEM_Result SHALL update to the assembled word on the HIGH -> DONE edge of a read and hold until the next read completes; writes never change it.
REQ-021 MEM_R_EN_in and MEM_W_EN_in both 1 SHALL be treated as a write.
REQ-022 In IDLE and DONE, SRAM outputs SHALL idle: SRAM_WE_N = 1, SRAM_DQ_oe = 0, SRAM_ADDR = 0, SRAM_DQ_out = 0.

Reset
REQ-023 rst low SHALL immediately force IDLE, counter 0, MEM_Result 0, SRAM_WE_N 1, SRAM_DQ_oe 0, freeze recomputed combinationally from inputs.
REQ-024 Reset mid-access SHALL abandon the access; a partial SRAM write is not repaired.

Configuration
REQ-025 Macro MEM_STAGE_LAST_WORD_CACHE_EN SHALL enable a one-entry cache (valid bit, 17-bit index tag, 32-bit data).
REQ-026 With it: read in IDLE whose index matches a valid entry SHALL hit: freeze 0, MEM_Result = cached data combinationally that cycle and registered on the same edge, FSM stays IDLE, no SRAM access.
REQ-027 With it: read misses fill the entry at HIGH -> DONE; writes update it at HIGH -> DONE (write-through, full SRAM latency); reset clears valid.
REQ-028 Without it: no cache storage, every access takes the REQ-017 latency.

Structure
REQ-029 State encoding and MEM_BASE default SHALL live in the shared processor package.
REQ-030 SRAM sequencing (FSM, counter, half assembly) SHALL be one sub-module, sram_controller; mem_stage holds passthroughs and the optional cache.

Verification
REQ-031 Write ALU_Res_in=1024, Val_Rm_in=32'hDEADBEEF -> SRAM_ADDR 0 with DQ 16'hBEEF for 2 cycles, then addr 1 with 16'hDEAD for 2 cycles, freeze high 5 cycles.
REQ-032 Read ALU_Res_in=1028, model returns 16'h5678 then 16'h1234 -> SRAM_ADDR 2 then 3, MEM_Result 32'h12345678 in DONE, freeze low in DONE.
REQ-033 Non-memory op (both enables 0, ALU_Res_in=7) -> freeze 0, SRAM_WE_N 1, ALU_Res_out 7 same cycle.
REQ-034 rst low during HIGH of a write -> SRAM_WE_N 1 immediately, state IDLE, MEM_Result 0.
REQ-035 With macro: two consecutive reads of 1028 -> second has freeze 0 and MEM_Result 32'h12345678 with no SRAM_ADDR activity; intervening write 32'h0 to 1028 -> second read returns 32'h0.
